spi_slave_if: RTL
=================

SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for spi_clk_in, spi_cs_n_in and spi_mosi_in (legal 2..3).
REQ-002 The block SHALL have port clk, input, 1, system clock; it is the single clock.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port spi_clk_in, input, 1, SPI SCLK from an external master (mode 0).
REQ-005 The block SHALL have port spi_cs_n_in, input, 1, active-low chip select.
REQ-006 The block SHALL have port spi_mosi_in, input, 1, master-out data.
REQ-007 The block SHALL have port spi_miso_out, output, 1, slave-out data.
REQ-008 The block SHALL have port spi_miso_oe, output, 1, MISO tri-state enable (1 = drive).
REQ-009 The block SHALL have port tx_data, input, 8, next byte to transmit.
REQ-010 The block SHALL have port tx_valid, input, 1, tx_data valid.
REQ-011 The block SHALL have port tx_ready, output, 1, TX holding register empty.
REQ-012 The block SHALL have port rx_data, output, 8, last received byte.
REQ-013 The block SHALL have port rx_valid, output, 1, one-cycle strobe, rx_data new.
REQ-014 The block SHALL have port tx_underrun, output, 1, one-cycle strobe, byte started with empty holding register.
REQ-015 The block SHALL have port busy, output, 1, high while in ACTIVE state.

Function
REQ-016 The block SHALL pass all three SPI inputs through SYNC_STAGES flops, then detect SCLK rise/fall and CS fall/rise from the last synchronizer stage versus a delay register.
REQ-017 The block SHALL support SCLK frequency up to clk/8; faster SCLK is out of specification.
REQ-018 The block SHALL implement FSM IDLE -> ACTIVE on CS fall, and ACTIVE -> IDLE on CS rise; no other transitions.
REQ-019 The block SHALL sample synchronized MOSI on each SCLK rise in ACTIVE, shifting MSB first into a 3-bit bit counter plus an 8-bit shift register.
REQ-020 The block SHALL, on the 8th rise, copy the shift register to rx_data, pulse rx_valid for exactly one clk, and wrap the bit counter to 0; rx_valid SHALL occur within SYNC_STAGES+2 clk of the raw SCLK edge.
REQ-021 The block SHALL have no RX backpressure; a new byte SHALL overwrite rx_data.
REQ-022 The block SHALL load the TX shift register at each byte start (CS fall, or first SCLK fall after a wrap), taking the holding register if full, else 0xFF with a one-cycle tx_underrun pulse.
REQ-023 The block SHALL drive spi_miso_out = TX shift register bit 7 and shift left on each SCLK fall that is not a byte start.
REQ-024 The block SHALL accept tx_data when tx_valid && tx_ready, which clears tx_ready the next cycle; a byte-start load SHALL set tx_ready the next cycle; a same-cycle load and accept SHALL leave the register full with new data.
REQ-025 The block SHALL hold spi_miso_oe = 1 only in ACTIVE, and spi_miso_out = 1 in IDLE.
REQ-026 The block SHALL, on CS rise mid-byte, discard the partial byte (no rx_valid), clear the bit counter, and keep the holding register content.
REQ-027 The block SHALL ignore SCLK edges and MOSI while in IDLE.

Reset
REQ-028 The block SHALL, on rst_n low, asynchronously set FSM=IDLE, synchronizers to CS=1/SCLK=0/MOSI=0, rx_data=0x00, rx_valid=0, tx_underrun=0, tx_ready=1, busy=0, spi_miso_oe=0, spi_miso_out=1, and empty the holding register; reset mid-transfer SHALL abort it with no strobes.

Verification
REQ-029 The bench SHALL preload tx 0xA5, master sends 0x3C at clk/8 -> rx_data=0x3C with one rx_valid pulse, MISO bits 1,0,1,0,0,1,0,1.
REQ-030 The bench SHALL run two back-to-back bytes 0x01,0x80 in one CS with tx 0x55 loaded and 0xAA supplied after the first start -> rx_valid x2, MISO returns 0x55 then 0xAA.
REQ-031 The bench SHALL run a byte with no tx loaded -> MISO 0xFF, tx_underrun pulses once at CS fall.
REQ-032 The bench SHALL raise CS after 5 bits -> no rx_valid, busy=0, the next full byte 0x96 is received correctly.
REQ-033 The bench SHALL assert rst_n low after 4 bits -> all outputs at reset values immediately, no strobes after release.
REQ-034 The bench SHALL toggle SCLK with CS high -> no rx_valid, spi_miso_oe stays 0.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: synchronises SCLK/CS/MOSI into clk, shifts bytes in/out MSB first.
// Latency: rx_valid SYNC_STAGES+1 clk after the raw 8th SCLK rise; MISO updates SYNC_STAGES+1 clk after a fall.
// Backpressure: none on RX (new byte overwrites rx_data); TX holding register accepts on tx_valid && tx_ready.
module spi_slave_if #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk_in,
    input  logic       spi_cs_n_in,
    input  logic       spi_mosi_in,
    output logic       spi_miso_out,
    output logic       spi_miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_dly_q;
    logic                   cs_dly_q;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;
    logic                   cs_rise;
    logic [2:0]             bit_cnt_q;
    logic [6:0]             rx_shift_q;
    logic [7:0]             rx_data_q;
    logic                   rx_valid_q;
    logic [7:0]             tx_shift_q;
    logic [7:0]             hold_q;
    logic                   hold_full_q;
    logic                   start_pend_q;
    logic                   tx_underrun_q;
    logic [7:0]             tx_load_d;
    logic                   byte_start;
    logic                   tx_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_in};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_in};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_in};
            sclk_dly_q  <= sclk_s;
            cs_dly_q    <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;

    // A byte starts on CS fall, or on the first SCLK fall after the bit counter wrapped.
    assign byte_start = ((state_q == IDLE) && cs_fall) ||
                        ((state_q == ACTIVE) && !cs_rise && sclk_fall && start_pend_q);
    assign tx_load_d  = hold_full_q ? hold_q : 8'hFF;
    assign tx_accept  = tx_valid && !hold_full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= 7'd0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            tx_shift_q    <= 8'hFF;
            hold_q        <= 8'h00;
            hold_full_q   <= 1'b0;
            start_pend_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q      <= ACTIVE;
                        bit_cnt_q    <= 3'd0;
                        start_pend_q <= 1'b0;
                        tx_shift_q   <= tx_load_d;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q      <= IDLE;
                        bit_cnt_q    <= 3'd0;
                        start_pend_q <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift_q <= {rx_shift_q[5:0], mosi_s};
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q    <= {rx_shift_q, mosi_s};
                            rx_valid_q   <= 1'b1;
                            start_pend_q <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (start_pend_q) begin
                            tx_shift_q   <= tx_load_d;
                            start_pend_q <= 1'b0;
                        end else begin
                            tx_shift_q <= {tx_shift_q[6:0], 1'b1};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Accept after load so a same-cycle load and accept leaves the register full.
            if (byte_start) begin
                tx_underrun_q <= ~hold_full_q;
                hold_full_q   <= 1'b0;
            end
            if (tx_accept) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign busy         = (state_q == ACTIVE);
    assign spi_miso_oe  = busy;
    assign spi_miso_out = busy ? tx_shift_q[7] : 1'b1;
    assign tx_ready     = ~hold_full_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign tx_underrun  = tx_underrun_q;

endmodule
